// File: rtl/sfifo_pkg.sv
// Shared definitions for the synchronous FIFO family.
//   RD_BUF_DEPTH   depth of the read-side output buffer
//   rd_lvl_t       occupancy type for that buffer (0..RD_BUF_DEPTH)
//   rd_credit_ok   true when one more read may be issued without overflowing
//                  the output buffer at the time its data returns
package sfifo_pkg;

  localparam int RD_BUF_DEPTH = 2;

  typedef logic [1:0] rd_lvl_t;

  // A new read is safe when the entries already committed (buffered plus the
  // one still returning from the FIFO), less the one leaving this cycle, leave
  // room for it.
  function automatic logic rd_credit_ok(input rd_lvl_t level,
                                        input logic    inflight,
                                        input logic    pop);
    logic [2:0] occ;
    logic [2:0] room;
    occ  = {1'b0, level} + {2'b00, inflight};
    room = 3'(RD_BUF_DEPTH) + {2'b00, pop};
    return occ < room;
  endfunction

endpackage

// File: rtl/sfifo_rd_buf.sv
// Two-entry register buffer feeding the read stream.
// Entry 0 is always the head, so the output data is a plain register and holds
// steady while the consumer stalls.
//   clk, rst_n    clock, async active-low reset
//   clear         drop all entries (wins over push/pop)
//   push, push_data  append one entry at the tail
//   pop           remove the head (caller only pops when level != 0)
//   head_data     current head entry
//   level         entries held, 0..2
module sfifo_rd_buf
  import sfifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  rd_lvl_t          level_q, level_d;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    level_d = level_q;
    if (clear) begin
      level_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (level_q == 2'd0) ent0_d = push_data;
          else                 ent1_d = push_data;
          if (level_q != 2'(RD_BUF_DEPTH)) level_d = level_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          level_d = level_q - 2'd1;
        end
        2'b11: begin
          // Level unchanged; the head advances and the new word lands behind it.
          if (level_q == 2'(RD_BUF_DEPTH)) begin
            ent0_d = ent1_q;
            ent1_d = push_data;
          end else begin
            ent0_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      level_q <= '0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      level_q <= level_d;
    end
  end

  assign head_data = ent0_q;
  assign level     = level_q;

  // The read credit rule makes this unreachable.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !clear && level_q == 2'(RD_BUF_DEPTH)));

endmodule

// File: rtl/sfifo_stream_reader.sv
// Read-side adapter for the synchronous FIFO: pops the FIFO and re-presents
// the words as a valid/ready stream at up to one beat per cycle, hiding the
// FIFO's one-cycle read latency behind a two-entry buffer.
//   clk, rst_n     clock, async active-low reset (shared with the FIFO)
//   fifo_rempty    FIFO empty flag
//   fifo_rinc      FIFO pop request (combinational, depends on m_ready)
//   fifo_rdata     FIFO read data, valid the cycle after fifo_rinc
//   m_valid/m_ready/m_data  output stream
//   flush          discard buffered and in-flight data this cycle
//   buf_level      output buffer occupancy
//   beat_cnt       wrapping count of accepted beats
module sfifo_stream_reader
  import sfifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_rempty,
  output logic             fifo_rinc,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  input  logic             flush,
  output logic [1:0]       buf_level,
  output logic [CNT_W-1:0] beat_cnt
);

  logic             armed_q, armed_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic pop;
  logic pop_eff;
  logic capture;

  assign pop     = m_valid & m_ready;
  assign pop_eff = pop & ~flush;
  // A word returning during a flush belongs to the discarded stream.
  assign capture = inflight_q & ~flush;

  // armed keeps the first post-reset cycle pop-free, so the FIFO leaving
  // reset on the same edge never sees a request it was not ready for.
  assign fifo_rinc = armed_q & ~fifo_rempty & ~flush &
                     rd_credit_ok(buf_level, inflight_q, pop);

  always_comb begin
    armed_d    = 1'b1;
    inflight_d = fifo_rinc & ~flush;
    beat_cnt_d = beat_cnt_q;
    if (pop_eff) beat_cnt_d = beat_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      armed_q    <= armed_d;
      inflight_q <= inflight_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  sfifo_rd_buf #(.WIDTH(WIDTH)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (flush),
    .push      (capture),
    .push_data (fifo_rdata),
    .pop       (pop_eff),
    .head_data (m_data),
    .level     (buf_level)
  );

  assign m_valid  = (buf_level != 2'd0);
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_sfifo_stream_reader.sv
module tb_sfifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, fed by a behavioural FIFO.
  logic        rst_n;
  logic        fifo_rempty, fifo_rinc;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        m_valid, m_ready, flush;
  logic [7:0]  m_data;
  logic [1:0]  buf_level;
  logic [15:0] beat_cnt;

  // Narrow-counter instance for the wrap check, fed by an always-full source.
  logic        rst_w_n, m_ready_w, w_rinc, w_valid;
  logic [7:0]  w_data;
  logic [1:0]  w_level;
  logic [3:0]  w_cnt;
  logic        w_rempty = 1'b0;
  logic        w_flush  = 1'b0;
  logic [7:0]  w_rdata  = 8'h5A;

  sfifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_rempty(fifo_rempty), .fifo_rinc(fifo_rinc),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .flush(flush), .buf_level(buf_level), .beat_cnt(beat_cnt)
  );

  sfifo_stream_reader #(.WIDTH(8), .CNT_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_w_n), .fifo_rempty(w_rempty), .fifo_rinc(w_rinc),
    .fifo_rdata(w_rdata), .m_valid(w_valid), .m_ready(m_ready_w), .m_data(w_data),
    .flush(w_flush), .buf_level(w_level), .beat_cnt(w_cnt)
  );

  // Behavioural FIFO: exact empty flag, data one cycle after the pop.
  logic [7:0] fmem [256];
  int wp = 0;
  int rp = 0;
  assign fifo_rempty = (wp == rp);
  always @(posedge clk) if (fifo_rinc) begin
    fifo_rdata <= fmem[rp & 255];
    rp <= rp + 1;
  end

  int ncmp = 0;
  int nerr = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic fifo_write(input logic [7:0] d);
    fmem[wp & 255] = d;
    wp++;
    exp_q.push_back(d);
  endtask

  // Called after settle: a beat visible now is accepted at the next edge.
  task automatic beat_check(input string tag);
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk({tag, "_unexpected"}, 32'(exp_q.size()), 1);
      else                   chk(tag, m_data, exp_q.pop_front());
    end
  endtask

  task automatic drain(input int n, input int budget, input string tag);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      settle();
      if (m_valid && m_ready) got++;
      beat_check(tag);
      step();
    end
    chk({tag, "_count"}, got, n);
  endtask

  initial begin
    int got;
    logic prev_stall;
    logic [7:0] prev_data;

    rst_n = 1'b0; rst_w_n = 1'b0;
    m_ready = 1'b1; m_ready_w = 1'b0; flush = 1'b0;

    // Reset with a non-empty FIFO.
    for (int i = 1; i <= 16; i++) fifo_write(8'(i));
    step(); step(); settle();
    chk("rst_rinc",  fifo_rinc, 0);
    chk("rst_valid", m_valid,   0);
    chk("rst_cnt",   beat_cnt,  0);
    chk("rst_level", buf_level, 0);
    chk("rst_data",  m_data,    0);

    rst_n = 1'b1; settle();
    chk("release_rinc", fifo_rinc, 0);

    // Streaming: first pop, then data two cycles later, then 16 back-to-back beats.
    step(); settle();
    chk("first_rinc",  fifo_rinc, 1);
    chk("first_valid", m_valid,   0);
    step(); settle();
    chk("lat_valid", m_valid, 0);
    step(); settle();
    for (int i = 0; i < 16; i++) begin
      chk("stream_valid", m_valid, 1);
      beat_check("stream_data");
      step(); settle();
    end
    chk("stream_cnt",  beat_cnt, 16);
    chk("stream_idle", m_valid,  0);

    // Backpressure: buffer fills to 2 and stops requesting.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_write(8'hA0 + 8'(i));
    repeat (5) step();
    settle();
    chk("bp_level", buf_level, 2);
    chk("bp_rinc",  fifo_rinc, 0);
    chk("bp_head",  m_data,    8'hA0);
    step(); settle();
    chk("bp_hold_valid", m_valid, 1);
    chk("bp_hold_data",  m_data,  8'hA0);
    m_ready = 1'b1;
    drain(8, 40, "bp");
    chk("bp_cnt",  beat_cnt, 24);
    chk("bp_left", exp_q.size(), 0);

    // Random ready over 200 random bytes, checking the stall-hold rule too.
    for (int i = 0; i < 200; i++) fifo_write(8'($urandom_range(0, 255)));
    got = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < 3000 && got < 200; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      settle();
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data",  m_data,  prev_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) got++;
      beat_check("rnd_data");
      step();
    end
    chk("rnd_count", got, 200);
    chk("rnd_cnt",   beat_cnt, 224);

    // Flush with one word buffered and one returning from the FIFO.
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_write(8'hC0 + 8'(i));
    repeat (5) step();
    settle();
    chk("fl_full", buf_level, 2);
    m_ready = 1'b1; settle();
    chk("fl_pre_rinc", fifo_rinc, 1);
    beat_check("fl_pre");
    step(); settle();
    chk("fl_level1", buf_level, 1);
    flush = 1'b1; settle();
    chk("fl_rinc", fifo_rinc, 0);
    step();
    flush = 1'b0;
    // C1 (buffered) and C2 (returning) are discarded.
    void'(exp_q.pop_front());
    void'(exp_q.pop_front());
    settle();
    chk("fl_valid", m_valid,   0);
    chk("fl_level", buf_level, 0);
    chk("fl_cnt",   beat_cnt,  225);
    drain(5, 30, "fl_post");
    chk("fl_final_cnt", beat_cnt, 230);

    // Counter wrap on the 4-bit instance.
    rst_w_n = 1'b1;
    repeat (6) step();
    settle();
    chk("w_level", w_level, 2);
    chk("w_cnt0",  w_cnt,   0);
    m_ready_w = 1'b1;
    repeat (15) step();
    chk("w_cnt15", w_cnt, 15);
    step();
    chk("w_cnt_wrap", w_cnt, 0);
    step();
    chk("w_cnt17", w_cnt, 1);

    // Reset mid-transfer returns everything to reset values at once.
    rst_w_n = 1'b0; settle();
    chk("w_rst_valid", w_valid, 0);
    chk("w_rst_level", w_level, 0);
    chk("w_rst_cnt",   w_cnt,   0);
    chk("w_rst_rinc",  w_rinc,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
